decoder_2to4_strobe: RTL and testbench



---
 rtl/decoder_2to4_strobe.sv | 75 +++++++
 tb/tb_decoder_2to4_strobe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2to4_strobe.sv
// decoder_2to4_strobe: registered 2-to-4 decoder with timed one-hot strobe,
// idle gap and saturating accept counter.
module decoder_2to4_strobe #(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] evt_count,
    input  logic             clr_count
);
    localparam int MX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW = (MX > 1) ? $clog2(MX) : 1;
    localparam logic [TW-1:0] HOLD_T = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_T = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [1:0] idx, idx_n;
    logic accept;

    assign in_ready = (state == IDLE);
    assign busy = (state != IDLE);
    assign accept = in_valid && in_ready;
    assign idx_n = accept ? in : idx;

    always_comb begin
        state_n = state;
        timer_n = timer;
        case (state)
            IDLE: begin
                state_n = accept ? HOLD : IDLE;
                timer_n = accept ? HOLD_T : timer;
            end
            HOLD: begin
                state_n = (timer != '0) ? HOLD : ((GAP_CYCLES == 0) ? IDLE : GAP);
                timer_n = (timer != '0) ? timer - 1'b1 : GAP_T;
            end
            GAP: begin
                state_n = (timer != '0) ? GAP : IDLE;
                timer_n = (timer != '0) ? timer - 1'b1 : timer;
            end
            default: state_n = IDLE;
        endcase
    end

    // out is registered from the next state so the strobe lands one cycle after accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            idx       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            evt_count <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            idx       <= idx_n;
            out       <= (state_n == HOLD) ? (4'b0001 << idx_n) : 4'b0000;
            out_valid <= (state_n == HOLD);
            evt_count <= clr_count ? '0 :
                         (accept && evt_count != {CNT_W{1'b1}}) ? evt_count + 1'b1 : evt_count;
        end
    end
endmodule

// File: tb/tb_decoder_2to4_strobe.sv
// tb_decoder_2to4_strobe: three configurations (H2/G1/W8, H2/G0/W8, H2/G1/W2)
// on shared stimulus, checked against a time-interval reference model.
module tb_decoder_2to4_strobe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] in = 2'b00;
    logic in_valid = 1'b0;
    logic clr_count = 1'b0;
    logic [3:0] o[3];
    logic ov[3], bz[3], rd[3];
    logic [7:0] ev0, ev1;
    logic [1:0] ev2;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    decoder_2to4_strobe #(.HOLD_CYCLES(2), .GAP_CYCLES(1), .CNT_W(8)) d0 (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(rd[0]),
        .out(o[0]), .out_valid(ov[0]), .busy(bz[0]), .evt_count(ev0), .clr_count(clr_count));
    decoder_2to4_strobe #(.HOLD_CYCLES(2), .GAP_CYCLES(0), .CNT_W(8)) d1 (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(rd[1]),
        .out(o[1]), .out_valid(ov[1]), .busy(bz[1]), .evt_count(ev1), .clr_count(clr_count));
    decoder_2to4_strobe #(.HOLD_CYCLES(2), .GAP_CYCLES(1), .CNT_W(2)) d2 (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(rd[2]),
        .out(o[2]), .out_valid(ov[2]), .busy(bz[2]), .evt_count(ev2), .clr_count(clr_count));

    // Reference model: an accept at edge a makes the strobe visible after edges
    // a..a+H-1, the block busy through a+H+G-1, and the next accept legal at a+H+G+1.
    int hc[3] = '{2, 2, 2};
    int gc[3] = '{1, 0, 1};
    int cm[3] = '{255, 255, 3};
    int e = 0;
    int last_e[3], free_at[3], cnt[3];
    logic [1:0] lidx[3];

    function automatic logic ok(int k);
        return in_valid && (e + 1 >= free_at[k]);
    endfunction
    function automatic logic [3:0] x_out(int k);
        return (e >= last_e[k] && e <= last_e[k] + hc[k] - 1) ? (4'b0001 << lidx[k]) : 4'b0000;
    endfunction
    function automatic logic x_busy(int k);
        return (e >= last_e[k]) && (e < free_at[k] - 1);
    endfunction
    function automatic int got_ev(int k);
        return (k == 0) ? int'(ev0) : (k == 1) ? int'(ev1) : int'(ev2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                last_e[k] <= -100;
                free_at[k] <= 0;
                cnt[k] <= 0;
                lidx[k] <= 2'b00;
            end
        end else begin
            e <= e + 1;
            for (int k = 0; k < 3; k++) begin
                cnt[k] <= clr_count ? 0 : (ok(k) && cnt[k] != cm[k]) ? cnt[k] + 1 : cnt[k];
                if (ok(k)) begin
                    last_e[k] <= e + 1;
                    free_at[k] <= e + 1 + hc[k] + gc[k] + 1;
                    lidx[k] <= in;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        in_valid = 1'b0;
        clr_count = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({o[k], ov[k], bz[k], rd[k]} !== 7'b0000_001 || got_ev(k) != 0)
                $display("FAIL reset[%0d] got out=%b ov=%b busy=%b rdy=%b cnt=%0d want 0000/0/0/1/0",
                         k, o[k], ov[k], bz[k], rd[k], got_ev(k));
            else passed++;
        end
        #9 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [3:0] want_o[4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic want_rd[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        in = 2'b10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int s = 0; s < 6; s++) begin
            if (s < 4) begin
                total++;
                if (o[0] !== want_o[s] || rd[0] !== want_rd[s])
                    $display("FAIL single step%0d got out=%b rdy=%b want %b/%b",
                             s, o[0], rd[0], want_o[s], want_rd[s]);
                else passed++;
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if ({o[k], ov[k], bz[k], rd[k]} !== {x_out(k), x_out(k) != 4'b0, x_busy(k), !x_busy(k)} ||
                    got_ev(k) != cnt[k])
                    $display("FAIL single_model[%0d] got %b/%b/%b/%b cnt=%0d want %b/%b/%0d",
                             k, o[k], ov[k], bz[k], rd[k], got_ev(k), x_out(k), x_busy(k), cnt[k]);
                else passed++;
            end
            tick();
        end
        total++;
        if (ev0 !== 8'd1) $display("FAIL single_count got %0d want 1", ev0);
        else passed++;
    endtask

    task automatic test_sweep();
        int n = 0;
        logic [3:0] want;
        settle();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        in = 2'b00;
        in_valid = 1'b1;
        for (int s = 1; s <= 16; s++) begin
            tick();
            if (last_e[0] == e) begin
                n++;
                in = 2'(n % 4);
            end
            want = ((s - 1) % 4 < 2) ? (4'b0001 << ((s - 1) / 4)) : 4'b0000;
            total++;
            if (o[0] !== want) $display("FAIL sweep_out edge%0d got %b want %b", s, o[0], want);
            else passed++;
            for (int k = 0; k < 3; k++) begin
                total++;
                if ({o[k], ov[k], bz[k], rd[k]} !== {x_out(k), x_out(k) != 4'b0, x_busy(k), !x_busy(k)} ||
                    got_ev(k) != cnt[k])
                    $display("FAIL sweep_model[%0d] got %b/%b/%b/%b cnt=%0d want %b/%b/%0d",
                             k, o[k], ov[k], bz[k], rd[k], got_ev(k), x_out(k), x_busy(k), cnt[k]);
                else passed++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (ev0 !== 8'd4 || ev1 !== 8'd6 || ev2 !== 2'd3)
            $display("FAIL sweep_counts got %0d/%0d/%0d want 4/6/3", ev0, ev1, ev2);
        else passed++;
    endtask

    task automatic test_busy_ignore();
        logic [3:0] want_o[3] = '{4'b1000, 4'b1000, 4'b0000};
        settle();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        in = 2'b11;
        in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            in = 2'($urandom_range(0, 2));
            in_valid = s[0];
            total++;
            if (o[0] !== want_o[s]) $display("FAIL busy_out step%0d got %b want %b", s, o[0], want_o[s]);
            else passed++;
            for (int k = 0; k < 3; k++) begin
                total++;
                if ({o[k], ov[k], bz[k], rd[k]} !== {x_out(k), x_out(k) != 4'b0, x_busy(k), !x_busy(k)} ||
                    got_ev(k) != cnt[k])
                    $display("FAIL busy_model[%0d] got %b/%b/%b/%b cnt=%0d want %b/%b/%0d",
                             k, o[k], ov[k], bz[k], rd[k], got_ev(k), x_out(k), x_busy(k), cnt[k]);
                else passed++;
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (ev0 !== 8'd1 || o[0] !== 4'b0000) $display("FAIL busy_count got %0d/%b want 1/0000", ev0, o[0]);
        else passed++;
    endtask

    task automatic test_counter();
        settle();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        in = 2'b01;
        in_valid = 1'b1;
        repeat (20) tick();
        total++;
        if (ev2 !== 2'd3 || ev0 !== 8'd5) $display("FAIL count_sat got %0d/%0d want 3/5", ev2, ev0);
        else passed++;
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        in_valid = 1'b0;
        total++;
        if (ev2 !== 2'd0 || ev0 !== 8'd0 || o[2] !== 4'b0010)
            $display("FAIL count_clr got %0d/%0d out=%b want 0/0/0010", ev2, ev0, o[2]);
        else passed++;
    endtask

    task automatic test_async_reset();
        settle();
        in = 2'b11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (o[0] !== 4'b1000) $display("FAIL areset_pre got %b want 1000", o[0]);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({o[k], ov[k], bz[k], rd[k]} !== 7'b0000_001 || got_ev(k) != 0)
                $display("FAIL areset[%0d] got out=%b ov=%b busy=%b rdy=%b cnt=%0d want 0000/0/0/1/0",
                         k, o[k], ov[k], bz[k], rd[k], got_ev(k));
            else passed++;
        end
        #3 rst_n = 1'b1;
        tick();
        in = 2'b01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (o[0] !== 4'b0010 || ov[0] !== 1'b1 || ev0 !== 8'd1)
            $display("FAIL areset_post got %b/%b/%0d want 0010/1/1", o[0], ov[0], ev0);
        else passed++;
    endtask

    task automatic test_random();
        settle();
        for (int s = 0; s < 300; s++) begin
            in = 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 2) != 0);
            clr_count = ($urandom_range(0, 15) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if ({o[k], ov[k], bz[k], rd[k]} !== {x_out(k), x_out(k) != 4'b0, x_busy(k), !x_busy(k)} ||
                    got_ev(k) != cnt[k])
                    $display("FAIL random[%0d] cyc%0d got %b/%b/%b/%b cnt=%0d want %b/%b/%0d",
                             k, s, o[k], ov[k], bz[k], rd[k], got_ev(k), x_out(k), x_busy(k), cnt[k]);
                else passed++;
            end
        end
        in_valid = 1'b0;
        clr_count = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_busy_ignore();
        test_counter();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
